// File: rtl/day_calendar.sv
// day_calendar: registered day/month/year calendar with a day prescaler,
// single-day step requests and a range-checked date load. Every output is
// a flop, so downstream next-day logic can consume tod combinationally.

// Bounded wrapping field counter (day 1..30, month 1..12).
// wrap flags the increment that takes the field from HI back to LO.
module day_calendar_field #(
  parameter int W  = 5,
  parameter int LO = 1,
  parameter int HI = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] val,
  output logic         wrap
);
  localparam logic [W-1:0] LOV = W'(LO);
  localparam logic [W-1:0] HIV = W'(HI);

  // >= rather than == so a field could never run past HI
  assign wrap = inc && (val >= HIV);

  // load has priority; otherwise step or wrap back to LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   val <= LOV;
    else if (ld)  val <= ld_val;
    else if (inc) val <= wrap ? LOV : val + 1'b1;
  end
endmodule

module day_calendar #(
  parameter int TICKS_PER_DAY = 86400,
  parameter int YEAR_W        = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              step,
  input  logic              set_valid,
  input  logic [4:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  output logic              set_ack,
  output logic              set_err,
  output logic [4:0]        tod,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              day_pulse,
  output logic              month_pulse,
  output logic              year_pulse
);
  localparam int PW = (TICKS_PER_DAY > 2) ? $clog2(TICKS_PER_DAY) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_DAY - 1);

  typedef struct packed {
    logic              vld;
    logic [4:0]        day;
    logic [3:0]        mon;
    logic [YEAR_W-1:0] yr;
  } set_req_t;

  set_req_t      req;
  logic [PW-1:0] cnt;
  logic          tick, adv, set_legal, set_bad;
  logic          day_wrap, mon_wrap;

  assign req = '{vld: set_valid, day: set_day, mon: set_month, yr: set_year};

  assign set_legal = req.vld && (req.day >= 5'd1) && (req.day <= 5'd30) &&
                     (req.mon >= 4'd1) && (req.mon <= 4'd12);
  assign set_bad   = req.vld && !set_legal;

  // tick and step collapse into one advance; a legal load masks both
  assign tick = en && (cnt == TERM);
  assign adv  = (tick || step) && !set_legal;

  // day prescaler: counts enabled cycles, restarts on terminal or legal load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (set_legal) cnt <= '0;
    else if (en)        cnt <= tick ? '0 : cnt + 1'b1;
  end

  day_calendar_field #(.W(5), .LO(1), .HI(30)) u_day (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (set_legal),
    .ld_val (req.day),
    .inc    (adv),
    .val    (tod),
    .wrap   (day_wrap)
  );

  day_calendar_field #(.W(4), .LO(1), .HI(12)) u_mon (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (set_legal),
    .ld_val (req.mon),
    .inc    (day_wrap),
    .val    (month),
    .wrap   (mon_wrap)
  );

  // year: free-running modulo 2^YEAR_W, bumped on month 12 -> 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         year <= '0;
    else if (set_legal) year <= req.yr;
    else if (mon_wrap)  year <= year + 1'b1;
  end

  // one-cycle status pulses, aligned with the updated date
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_ack     <= 1'b0;
      set_err     <= 1'b0;
      day_pulse   <= 1'b0;
      month_pulse <= 1'b0;
      year_pulse  <= 1'b0;
    end else begin
      set_ack     <= set_legal;
      set_err     <= set_bad;
      day_pulse   <= adv;
      month_pulse <= day_wrap;
      year_pulse  <= mon_wrap;
    end
  end
endmodule

// File: tb/tb_day_calendar.sv
// Bench for day_calendar: vector table, hand-written corner sequences and a
// randomized run against a linear day-count reference model.
module tb_day_calendar;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, step = 1'b0, set_valid = 1'b0;
  logic [4:0]  set_day = '0;
  logic [3:0]  set_month = '0;
  logic [11:0] set_year = '0;

  logic        a_ack, a_err, a_dp, a_mp, a_yp;
  logic [4:0]  a_tod;
  logic [3:0]  a_mon;
  logic [11:0] a_yr;
  logic        b_ack, b_err, b_dp, b_mp, b_yp;
  logic [4:0]  b_tod;
  logic [3:0]  b_mon;
  logic [3:0]  b_yr;

  int total = 0;
  int bad   = 0;

  day_calendar #(.TICKS_PER_DAY(T), .YEAR_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .step(step), .set_valid(set_valid),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .set_ack(a_ack), .set_err(a_err), .tod(a_tod), .month(a_mon), .year(a_yr),
    .day_pulse(a_dp), .month_pulse(a_mp), .year_pulse(a_yp));

  day_calendar #(.TICKS_PER_DAY(T), .YEAR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .step(step), .set_valid(set_valid),
    .set_day(set_day), .set_month(set_month), .set_year(set_year[3:0]),
    .set_ack(b_ack), .set_err(b_err), .tod(b_tod), .month(b_mon), .year(b_yr),
    .day_pulse(b_dp), .month_pulse(b_mp), .year_pulse(b_yp));

  always #5 clk = ~clk;

  // observation word: {tod, month, year(12), ack, err, dp, mp, yp}
  function automatic logic [25:0] obs_a();
    return {a_tod, a_mon, a_yr, a_ack, a_err, a_dp, a_mp, a_yp};
  endfunction
  function automatic logic [25:0] obs_b();
    return {b_tod, b_mon, 8'd0, b_yr, b_ack, b_err, b_dp, b_mp, b_yp};
  endfunction
  function automatic logic [25:0] ex(int d, int m, int y, logic [4:0] p);
    return {5'(d), 4'(m), 12'(y), p};
  endfunction

  task automatic check(string nm, logic [25:0] act, logic [25:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got d=%0d m=%0d y=%0d p=%b, want d=%0d m=%0d y=%0d p=%b",
               nm, act[25:21], act[20:17], act[16:5], act[4:0],
               exp[25:21], exp[20:17], exp[16:5], exp[4:0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic e, logic s, logic v, int d, int m, int y);
    en = e; step = s; set_valid = v;
    set_day = 5'(d); set_month = 4'(m); set_year = 12'(y);
  endtask

  // ---------------- reference model: date as a linear day number ---------
  longint mdays;
  int     mcnt;
  localparam longint PERIOD = 360 * 4096;

  task automatic model_reset();
    mdays = 0; mcnt = 0;
  endtask

  function automatic logic [25:0] model_apply(logic e, logic s, logic v,
                                              logic [4:0] d, logic [3:0] m,
                                              logic [11:0] y);
    logic legal, ack, err, tk, adv, mp, yp;
    int dd, mm, yy;
    legal = v && d >= 1 && d <= 30 && m >= 1 && m <= 12;
    ack = 0; err = 0; adv = 0; tk = 0;
    if (legal) begin
      mdays = longint'(y) * 360 + longint'(int'(m) - 1) * 30 + longint'(int'(d) - 1);
      mcnt  = 0;
      ack   = 1;
    end else begin
      err = v;
      if (e) begin
        mcnt++;
        if (mcnt == T) begin mcnt = 0; tk = 1; end
      end
      adv = tk || s;
      if (adv) mdays = (mdays + 1) % PERIOD;
    end
    dd = int'(mdays % 30) + 1;
    mm = int'((mdays / 30) % 12) + 1;
    yy = int'(mdays / 360);
    mp = adv && dd == 1;
    yp = mp && mm == 1;
    return ex(dd, mm, yy, {ack, err, adv, mp, yp});
  endfunction

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_a", obs_a(), ex(1, 1, 0, 5'b0));
    check("reset_b", obs_b(), ex(1, 1, 0, 5'b0));
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------------------------------
  typedef struct {
    string       name;
    logic        en, step, sv;
    int          sd, sm, sy;
    logic [25:0] exp;
  } vec_t;

  function automatic vec_t mk(string n, logic e, logic s, logic v, int d, int m,
                              int y, int ed, int em, int ey, logic [4:0] p);
    vec_t r;
    r.name = n; r.en = e; r.step = s; r.sv = v;
    r.sd = d; r.sm = m; r.sy = y; r.exp = ex(ed, em, ey, p);
    return r;
  endfunction

  vec_t tbl[13];

  initial begin
    // pulse bits below: {ack, err, day, month, year}
    tbl[0]  = mk("step1",        0, 1, 0,  0,  0,    0,  2,  1,    0, 5'b00100);
    tbl[1]  = mk("ld_30_12_5",   0, 0, 1, 30, 12,    5, 30, 12,    5, 5'b10000);
    tbl[2]  = mk("step_ywrap",   0, 1, 0,  0,  0,    0,  1,  1,    6, 5'b00111);
    tbl[3]  = mk("ld_day0",      0, 0, 1,  0,  5,    9,  1,  1,    6, 5'b01000);
    tbl[4]  = mk("ld_mon13",     0, 0, 1, 10, 13,    9,  1,  1,    6, 5'b01000);
    tbl[5]  = mk("ld_day31",     0, 0, 1, 31,  5,    9,  1,  1,    6, 5'b01000);
    tbl[6]  = mk("idle",         0, 0, 0,  0,  0,    0,  1,  1,    6, 5'b00000);
    tbl[7]  = mk("ld_29_3_7",    0, 0, 1, 29,  3,    7, 29,  3,    7, 5'b10000);
    tbl[8]  = mk("step_and_err", 0, 1, 1,  0,  0,    0, 30,  3,    7, 5'b01100);
    tbl[9]  = mk("step_mwrap",   0, 1, 0,  0,  0,    0,  1,  4,    7, 5'b00110);
    tbl[10] = mk("ld_max",       0, 0, 1, 30, 12, 4095, 30, 12, 4095, 5'b10000);
    tbl[11] = mk("step_y12wrap", 0, 1, 0,  0,  0,    0,  1,  1,    0, 5'b00111);
    tbl[12] = mk("ld_over_step", 0, 1, 1,  1,  1,    1,  1,  1,    1, 5'b10000);

    #1;
    // seq: free-running prescaler, day_pulse every T enabled cycles
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      check($sformatf("presc_c%0d", c), obs_a(),
            ex(1 + c / T, 1, 0, {2'b00, (c % T) == 0, 2'b00}));
    end

    // table
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].step, tbl[i].sv, tbl[i].sd, tbl[i].sm, tbl[i].sy);
      cyc();
      check(tbl[i].name, obs_a(), tbl[i].exp);
    end
    drive(0, 0, 0, 0, 0, 0);

    // seq: step coincident with prescaler terminal at tod=29
    do_reset();
    drive(0, 0, 1, 29, 1, 0); cyc();
    check("co_ld", obs_a(), ex(29, 1, 0, 5'b10000));
    drive(1, 0, 0, 0, 0, 0);
    for (int c = 1; c < T; c++) begin
      cyc();
      check($sformatf("co_pre%0d", c), obs_a(), ex(29, 1, 0, 5'b0));
    end
    step = 1'b1; cyc(); step = 1'b0;
    check("co_single", obs_a(), ex(30, 1, 0, 5'b00100));
    for (int c = 1; c <= T; c++) begin
      cyc();
      if (c < T) check($sformatf("co_post%0d", c), obs_a(), ex(30, 1, 0, 5'b0));
      else       check("co_restart", obs_a(), ex(1, 2, 0, 5'b00110));
    end

    // seq: legal load beats step and tick together (prescaler now 0)
    for (int c = 1; c < T; c++) cyc();
    drive(1, 1, 1, 15, 6, 100); cyc();
    check("ld_beats_adv", obs_a(), ex(15, 6, 100, 5'b10000));
    drive(1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= T; c++) begin
      cyc();
      if (c < T) check($sformatf("ld_post%0d", c), obs_a(), ex(15, 6, 100, 5'b0));
      else       check("ld_next_tick", obs_a(), ex(16, 6, 100, 5'b00100));
    end

    // seq: 4-bit year wrap, then asynchronous reset mid-count
    drive(0, 0, 1, 30, 12, 15); cyc();
    check("yw_ld", obs_b(), ex(30, 12, 15, 5'b10000));
    drive(0, 1, 0, 0, 0, 0); cyc();
    check("yw_step", obs_b(), ex(1, 1, 0, 5'b00111));
    drive(1, 0, 0, 0, 0, 0); cyc(); cyc();
    #2 rst_n = 1'b0; #1;
    check("async_rst_a", obs_a(), ex(1, 1, 0, 5'b0));
    check("async_rst_b", obs_b(), ex(1, 1, 0, 5'b0));

    // randomized run against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        e, s, v;
      logic [4:0]  d;
      logic [3:0]  m;
      logic [11:0] y;
      logic [25:0] want;
      int          dsel[6];
      int          msel[6];
      dsel = '{0, 1, 29, 30, 31, 15};
      msel = '{0, 1, 11, 12, 13, 6};
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 9) == 0);
      d = 5'(($urandom_range(0, 1) == 0) ? dsel[$urandom_range(0, 5)] : $urandom_range(0, 31));
      m = 4'(($urandom_range(0, 1) == 0) ? msel[$urandom_range(0, 5)] : $urandom_range(0, 15));
      y = 12'(($urandom_range(0, 3) == 0) ? 4095 : $urandom_range(0, 4095));
      en = e; step = s; set_valid = v; set_day = d; set_month = m; set_year = y;
      want = model_apply(e, s, v, d, m, y);
      cyc();
      check($sformatf("rand%0d", n), obs_a(), want);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/day_calendar.md
# day_calendar

Sequential calendar register that generates the current day-of-month `tod` (1..30), month and year for the downstream next-day/day-after logic (`todtom`/`toddat`), which consume `tod` combinationally. It holds the date in registers. It advances the date once per `TICKS_PER_DAY` enabled clocks or on an explicit `step`. It also accepts a validated date load.

## Interface
- `TICKS_PER_DAY`, 86400: enabled clock cycles per day. Must be ≥ 2.
- `YEAR_W`, 12: year counter width.

- `clk` input 1: clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: prescaler enable.
- `step` input 1: single-cycle request to advance one day.
- `set_valid` input 1: load request, sampled every cycle.
- `set_day` input 5: load day, legal range 1..30.
- `set_month` input 4: load month, legal range 1..12.
- `set_year` input YEAR_W: load year.
- `set_ack` output 1: pulse, legal load accepted.
- `set_err` output 1: pulse, illegal load rejected.
- `tod` output 5: current day, 1..30.
- `month` output 4: current month, 1..12.
- `year` output YEAR_W: current year.
- `day_pulse` output 1: pulse, day advanced.
- `month_pulse` output 1: pulse, month rolled over (day 30→1).
- `year_pulse` output 1: pulse, year rolled over (month 12→1).

## Operation
- Reset (`rst_n`=0, asynchronous):
  - `tod`=1, `month`=1, `year`=0, prescaler=0.
  - All pulse outputs (`set_ack`, `set_err`, `day_pulse`, `month_pulse`, `year_pulse`)=0.
- Prescaler:
  - Counts 0..TICKS_PER_DAY-1 while `en`=1 and holds while `en`=0.
  - At TICKS_PER_DAY-1 with `en`=1 it raises an internal `tick` and returns to 0.
- Advance request: `adv` = `tick` OR `step`. If both are asserted in the same cycle, the date advances by exactly one day.
- Advance rule:
  - `tod`<30: `tod`+1.
  - `tod`=30: `tod`=1, and `month_pulse` is raised.
    - `month`<12: `month`+1.
    - `month`=12: `month`=1, `year`+1 (wraps 2^YEAR_W-1→0), and `year_pulse` is raised.
- Load:
  - Legal when 1≤`set_day`≤30 and 1≤`set_month`≤12. Any `set_year` value is legal.
  - A legal load writes all three fields, clears the prescaler to 0 and pulses `set_ack`.
  - An illegal load changes no state (prescaler included) and pulses `set_err`.
- Priority in a single cycle: legal load > advance.
  - A legal load suppresses any `adv` in the same cycle. No `day_pulse`, `month_pulse` or `year_pulse` is raised.
  - An illegal load does not block `adv`. The advance and `set_err` both occur.
- Date fields can never hold out-of-range values. Downstream logic may rely on `tod`∈1..30.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Event sampled at edge N → new date and its pulses visible after edge N, for exactly one cycle.
- `day_pulse` is high in the same cycle as the updated `tod`, and `month_pulse`/`year_pulse` align with it.
- Prescaler period: with `en` held high and no load, `day_pulse` fires every TICKS_PER_DAY cycles. The first fire is TICKS_PER_DAY cycles after reset release or after a legal load.
- `step` is level-sampled. Held high for k cycles, it advances k days.
- Reset asserted mid-count clears everything immediately. Counting resumes from prescaler 0 on the first edge after release.

## Test plan
- Reset, then `en`=1 with TICKS_PER_DAY=4:
  - `day_pulse` at cycles 4, 8, 12.
  - `tod` sequence 1→2→3→4.
  - `month`=1, `year`=0 throughout.
- Load 30/12/5, then `step` one cycle:
  - `set_ack` one cycle.
  - Next date `tod`=1, `month`=1, `year`=6.
  - `day_pulse`, `month_pulse` and `year_pulse` all high in the same cycle.
- Load with `set_day`=0, then with `set_month`=13:
  - `set_err` pulses each time, `set_ack`=0.
  - Date and prescaler unchanged.
- `step` coincident with prescaler terminal at `tod`=29:
  - `tod`=30, a single `day_pulse`.
  - Prescaler restarts at 0.
- Legal load 15/6/100 coincident with `step` and `tick`:
  - Result is 15/6/100, `set_ack`=1.
  - No advance pulses, next tick TICKS_PER_DAY cycles later.
- Year wrap with YEAR_W=4:
  - Load 30/12/15, then `step`.
  - Result `year`=0, `year_pulse`=1.
  - Assert `rst_n`=0 mid-count: outputs 1/1/0 immediately.
